// File: rtl/general_register_write_arbiter.sv
// general_register_write_arbiter
//
// Shares the single write port of the general register file (EAX..EDI)
// between NUM_REQ write-back requesters. Each request carries the raw
// instruction register field, the w bit and the operand size. These are
// decoded into a register index, a byte-enable mask and lane-aligned data.
// One requester is granted per cycle in round-robin order, and the write is
// presented to the register file as a registered single-cycle strobe.
//
// Optional feature macro: GENERAL_REGISTER_WRITE_COMBINE_EN
//   When defined, the winner and exactly one other valid requester that
//   target the same register with disjoint byte enables are granted together
//   and merged into one write (e.g. AL + AH -> enables 0011).
//   When undefined, exactly one grant per cycle and no merge logic.
//
// Parameters:
//   NUM_REQ     number of requesters (2..4)
//   DATA_WIDTH  register width (32 for this datapath)
//
// Ports:
//   clock                 system clock, rising edge
//   reset_n               synchronous active-low reset
//   req_valid[i]          requester i wants to write
//   req_ready[i]          requester i is granted this cycle
//   req_register          3-bit instruction register field per requester
//   req_w_in_instruction  opcode carries a w bit
//   req_w                 w bit value (ignored unless w_in_instruction)
//   req_operand_size_32   1 = 32-bit operand, 0 = 16-bit operand
//   req_data              right-justified write value per requester
//   wr_hold               register file cannot accept a write this cycle
//   wr_enable             registered write strobe (one cycle per write)
//   wr_index              register index 0..7
//   wr_byte_enable        byte lanes to write
//   wr_data               lane-aligned write data
//
// Handshake: a transfer on requester i happens on a rising edge where
// req_valid[i] and req_ready[i] are both high. req_ready is combinational
// from req_valid, wr_hold and reset_n; req_valid must not depend on
// req_ready, and a requester holds valid and payload stable until accepted.

module general_register_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*3-1:0]          req_register,
    input  logic [NUM_REQ-1:0]            req_w_in_instruction,
    input  logic [NUM_REQ-1:0]            req_w,
    input  logic [NUM_REQ-1:0]            req_operand_size_32,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          wr_hold,
    output logic                          wr_enable,
    output logic [2:0]                    wr_index,
    output logic [3:0]                    wr_byte_enable,
    output logic [DATA_WIDTH-1:0]         wr_data
);

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    // Per-requester decoded write
    logic [2:0]            dec_index [NUM_REQ];
    logic [3:0]            dec_be    [NUM_REQ];
    logic [DATA_WIDTH-1:0] dec_data  [NUM_REQ];

    // Arbitration state and decisions
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic             win_found;
    logic [PTR_W-1:0] partner;
    logic             partner_found;
    logic             accept;
    logic [PTR_W-1:0] last_granted;

    logic [2:0]            next_index;
    logic [3:0]            next_be;
    logic [DATA_WIDTH-1:0] next_data;

    // ------------------------------------------------------------------
    // Width decode, one instance per requester
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_decode
        logic [2:0]            reg_field;
        logic [DATA_WIDTH-1:0] raw;
        logic                  byte_op;

        assign reg_field = req_register[g*3 +: 3];
        assign raw       = req_data[g*DATA_WIDTH +: DATA_WIDTH];
        // Only an opcode with a w bit can select an 8-bit write.
        assign byte_op   = req_w_in_instruction[g] & ~req_w[g];

        always_comb begin
            dec_index[g] = reg_field;
            dec_be[g]    = req_operand_size_32[g] ? 4'b1111 : 4'b0011;
            dec_data[g]  = raw;
            if (byte_op) begin
                if (!reg_field[2]) begin
                    // AL, CL, DL, BL: low byte of EAX..EBX
                    dec_index[g] = reg_field;
                    dec_be[g]    = 4'b0001;
                    dec_data[g]  = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
                end else begin
                    // AH, CH, DH, BH: second byte of EAX..EBX
                    dec_index[g] = {1'b0, reg_field[1:0]};
                    dec_be[g]    = 4'b0010;
                    dec_data[g]  = {{(DATA_WIDTH-16){1'b0}}, raw[7:0], 8'h00};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin winner: first valid requester at or after rr_ptr
    // ------------------------------------------------------------------
    always_comb begin
        int               c;
        logic [PTR_W-1:0] cand;
        win_found = 1'b0;
        winner    = '0;
        c         = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(rr_ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            cand = PTR_W'(c);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                winner    = cand;
            end
        end
    end

`ifdef GENERAL_REGISTER_WRITE_COMBINE_EN
    // Search the other requesters in cyclic order after the winner. Any
    // requester between rr_ptr and the winner is invalid, so a partner found
    // here is always the later of the two in round-robin order.
    always_comb begin
        int               c;
        int               matches;
        logic [PTR_W-1:0] cand;
        partner = '0;
        matches = 0;
        c       = 0;
        cand    = '0;
        for (int k = 1; k < NUM_REQ; k++) begin
            c = int'(winner) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            cand = PTR_W'(c);
            if (win_found && req_valid[cand] &&
                dec_index[cand] == dec_index[winner] &&
                (dec_be[cand] & dec_be[winner]) == 4'b0000) begin
                if (matches == 0) partner = cand;
                matches = matches + 1;
            end
        end
        // Merge only when the match is unambiguous.
        partner_found = (matches == 1);
    end

    always_comb begin
        next_index = dec_index[winner];
        next_be    = dec_be[winner];
        next_data  = dec_data[winner];
        if (partner_found) begin
            next_be = dec_be[winner] | dec_be[partner];
            for (int b = 0; b < 4; b++) begin
                next_data[b*8 +: 8] = dec_be[winner][b] ? dec_data[winner][b*8 +: 8]
                                                        : dec_data[partner][b*8 +: 8];
            end
        end
    end
`else
    assign partner       = '0;
    assign partner_found = 1'b0;
    assign next_index    = dec_index[winner];
    assign next_be       = dec_be[winner];
    assign next_data     = dec_data[winner];
`endif

    assign accept       = reset_n & win_found & ~wr_hold;
    assign last_granted = partner_found ? partner : winner;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
        assign req_ready[g] = accept &
                              ((winner == PTR_W'(g)) |
                               (partner_found & (partner == PTR_W'(g))));
    end

    // ------------------------------------------------------------------
    // Pointer and registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr         <= '0;
            wr_enable      <= 1'b0;
            wr_index       <= 3'd0;
            wr_byte_enable <= 4'b0000;
            wr_data        <= '0;
        end else if (accept) begin
            rr_ptr         <= (int'(last_granted) == NUM_REQ - 1) ? '0
                                                                  : last_granted + 1'b1;
            wr_enable      <= 1'b1;
            wr_index       <= next_index;
            wr_byte_enable <= next_be;
            wr_data        <= next_data;
        end else begin
            // Index, enables and data hold their last values.
            wr_enable      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_general_register_write_arbiter.sv
module tb_general_register_write_arbiter;

  localparam int N = 2;

  logic            clock;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*3-1:0]  req_register;
  logic [N-1:0]    req_w_in_instruction;
  logic [N-1:0]    req_w;
  logic [N-1:0]    req_operand_size_32;
  logic [N*32-1:0] req_data;
  logic            wr_hold;
  logic            wr_enable;
  logic [2:0]      wr_index;
  logic [3:0]      wr_byte_enable;
  logic [31:0]     wr_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  rg;
    logic        win;
    logic        w;
    logic        s32;
    logic [31:0] data;
    logic [2:0]  e_idx;
    logic [3:0]  e_be;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[12];

  general_register_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(32)) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_register         (req_register),
    .req_w_in_instruction (req_w_in_instruction),
    .req_w                (req_w),
    .req_operand_size_32  (req_operand_size_32),
    .req_data             (req_data),
    .wr_hold              (wr_hold),
    .wr_enable            (wr_enable),
    .wr_index             (wr_index),
    .wr_byte_enable       (wr_byte_enable),
    .wr_data              (wr_data)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    wr_hold   = 1'b0;
    repeat (2) @(negedge clock);
    reset_n   = 1'b1;
  endtask

  // driver
  task automatic set_req(input int i, input logic [2:0] rg, input logic win,
                         input logic w, input logic s32, input logic [31:0] data);
    req_register[i*3 +: 3]     = rg;
    req_w_in_instruction[i]    = win;
    req_w[i]                   = w;
    req_operand_size_32[i]     = s32;
    req_data[i*32 +: 32]       = data;
  endtask

  // checker
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_write(input string name, input logic [2:0] idx,
                             input logic [3:0] be, input logic [31:0] data);
    check({name, "_en"},   32'(wr_enable), 32'd1);
    check({name, "_idx"},  32'(wr_index), 32'(idx));
    check({name, "_be"},   32'(wr_byte_enable), 32'(be));
    check({name, "_data"}, wr_data, data);
  endtask

  // reference decode for the sweep
  task automatic ref_decode(input logic [2:0] rg, input logic win, input logic w,
                            input logic s32, input logic [31:0] d,
                            output logic [2:0] idx, output logic [3:0] be,
                            output logic [31:0] data);
    if (win && !w) begin
      if (rg < 3'd4) begin
        idx = rg; be = 4'b0001; data = d & 32'h0000_00FF;
      end else begin
        idx = rg - 3'd4; be = 4'b0010; data = (d & 32'h0000_00FF) << 8;
      end
    end else begin
      idx = rg; be = s32 ? 4'b1111 : 4'b0011; data = d;
    end
  endtask

  initial begin
    int pulses;
    logic [2:0]  e_idx;
    logic [3:0]  e_be;
    logic [31:0] e_data;
    logic [31:0] rnd;

    vecs[0]  = '{3'd4, 1'b1, 1'b0, 1'b0, 32'h0000_00A5, 3'd0, 4'b0010, 32'h0000_A500};
    vecs[1]  = '{3'd6, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 3'd6, 4'b0011, 32'h1234_5678};
    vecs[2]  = '{3'd6, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 3'd6, 4'b1111, 32'h1234_5678};
    vecs[3]  = '{3'd0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 3'd0, 4'b0001, 32'h0000_00EF};
    vecs[4]  = '{3'd3, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 3'd3, 4'b0001, 32'h0000_000D};
    vecs[5]  = '{3'd7, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 3'd3, 4'b0010, 32'h0000_0D00};
    vecs[6]  = '{3'd5, 1'b1, 1'b1, 1'b1, 32'h89AB_CDEF, 3'd5, 4'b1111, 32'h89AB_CDEF};
    vecs[7]  = '{3'd2, 1'b1, 1'b1, 1'b0, 32'h89AB_CDEF, 3'd2, 4'b0011, 32'h89AB_CDEF};
    vecs[8]  = '{3'd1, 1'b0, 1'b0, 1'b1, 32'h0000_FFFF, 3'd1, 4'b1111, 32'h0000_FFFF};
    vecs[9]  = '{3'd4, 1'b0, 1'b1, 1'b0, 32'hFFFF_1234, 3'd4, 4'b0011, 32'hFFFF_1234};
    vecs[10] = '{3'd5, 1'b1, 1'b0, 1'b0, 32'h0000_0177, 3'd1, 4'b0010, 32'h0000_7700};
    vecs[11] = '{3'd7, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 3'd7, 4'b1111, 32'h0000_0001};

    req_valid = '0;
    wr_hold   = 1'b0;
    reset_n   = 1'b0;
    set_req(0, 3'd0, 1'b0, 1'b0, 1'b1, 32'h0);
    set_req(1, 3'd1, 1'b0, 1'b0, 1'b1, 32'h0);

    // reset state: ready stays low while reset is held, outputs cleared
    @(negedge clock);
    req_valid = 2'b11;
    #1 check("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    check("rst_en",   32'(wr_enable), 32'd0);
    check("rst_idx",  32'(wr_index), 32'd0);
    check("rst_be",   32'(wr_byte_enable), 32'd0);
    check("rst_data", wr_data, 32'd0);
    req_valid = '0;
    reset_n   = 1'b1;
    @(negedge clock);

    // table-driven decode vectors on requester 0
    for (int i = 0; i < 12; i++) begin
      set_req(0, vecs[i].rg, vecs[i].win, vecs[i].w, vecs[i].s32, vecs[i].data);
      req_valid = 2'b01;
      #1 check("vec_ready", 32'(req_ready), 32'd1);
      @(negedge clock);
      check_write($sformatf("vec%0d", i), vecs[i].e_idx, vecs[i].e_be, vecs[i].e_data);
      req_valid = '0;
    end
    @(negedge clock);
    check("idle_en", 32'(wr_enable), 32'd0);

    // full width sweep on requester 1
    for (int k = 0; k < 64; k++) begin
      rnd = $urandom;
      set_req(1, 3'(k & 7), k[3], k[4], k[5], rnd);
      ref_decode(3'(k & 7), k[3], k[4], k[5], rnd, e_idx, e_be, e_data);
      req_valid = 2'b10;
      @(negedge clock);
      check_write("sweep", e_idx, e_be, e_data);
      req_valid = '0;
    end

    // alternation: both valid for 6 cycles
    do_reset();
    set_req(0, 3'd2, 1'b0, 1'b0, 1'b1, 32'hAAAA_0000);
    set_req(1, 3'd5, 1'b0, 1'b0, 1'b1, 32'h0000_BBBB);
    req_valid = 2'b11;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      #1 check("alt_ready", 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      exp_q.push_back((c % 2 == 0) ? 32'hAAAA_0000 : 32'h0000_BBBB);
      @(negedge clock);
      if (wr_enable) begin
        pulses++;
        if (exp_q.size() > 0) check("alt_data", wr_data, exp_q.pop_front());
      end
    end
    req_valid = '0;
    check("alt_pulses", 32'(pulses), 32'd6);
    check("alt_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // hold: grant 0, then 3 held cycles, then grant goes to 1
    do_reset();
    req_valid = 2'b11;
    #1 check("hold_pre_ready", 32'(req_ready), 32'd1);
    @(negedge clock);
    check_write("hold_pre", 3'd2, 4'b1111, 32'hAAAA_0000);
    wr_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check("hold_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
      check("hold_en", 32'(wr_enable), 32'd0);
    end
    check("hold_data_kept", wr_data, 32'hAAAA_0000);
    wr_hold = 1'b0;
    #1 check("hold_post_ready", 32'(req_ready), 32'd2);
    @(negedge clock);
    check_write("hold_post", 3'd5, 4'b1111, 32'h0000_BBBB);
    req_valid = '0;

    // reset mid-stream with a write registered
    do_reset();
    req_valid = 2'b11;
    #1 check("mrst_ready0", 32'(req_ready), 32'd1);
    @(negedge clock);
    check("mrst_en_before", 32'(wr_enable), 32'd1);
    reset_n = 1'b0;
    #1 check("mrst_ready_in_reset", 32'(req_ready), 32'd0);
    @(negedge clock);
    check("mrst_en",   32'(wr_enable), 32'd0);
    check("mrst_idx",  32'(wr_index), 32'd0);
    check("mrst_be",   32'(wr_byte_enable), 32'd0);
    check("mrst_data", wr_data, 32'd0);
    reset_n = 1'b1;
    #1 check("mrst_first_grant", 32'(req_ready), 32'd1);
    @(negedge clock);
    check_write("mrst_after", 3'd2, 4'b1111, 32'hAAAA_0000);
    req_valid = '0;

    // AL + AH in the same cycle
    do_reset();
    set_req(0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0011);
    set_req(1, 3'd4, 1'b1, 1'b0, 1'b1, 32'h0000_0022);
    req_valid = 2'b11;
`ifdef GENERAL_REGISTER_WRITE_COMBINE_EN
    #1 check("comb_ready", 32'(req_ready), 32'd3);
    @(negedge clock);
    check_write("comb", 3'd0, 4'b0011, 32'h0000_2211);
    req_valid = '0;
    @(negedge clock);
    check("comb_single", 32'(wr_enable), 32'd0);
`else
    #1 check("comb_ready0", 32'(req_ready), 32'd1);
    @(negedge clock);
    check_write("comb_al", 3'd0, 4'b0001, 32'h0000_0011);
    req_valid = 2'b10;
    #1 check("comb_ready1", 32'(req_ready), 32'd2);
    @(negedge clock);
    check_write("comb_ah", 3'd0, 4'b0010, 32'h0000_2200);
    req_valid = '0;
`endif

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
